// File: rtl/hazard_flush_ctrl_pkg.sv
// Shared pipeline-control types: controller state, NZCV bit positions and the
// request bundle the stages present to the hazard/flush controller.
package pipe_ctrl_pkg;
   localparam int REG_W = 4;

   typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_t;

   typedef enum int {NZCV_V = 0, NZCV_C = 1, NZCV_Z = 2, NZCV_N = 3} nzcv_idx_t;

   typedef struct packed {
      logic [REG_W-1:0] id_src1;
      logic [REG_W-1:0] id_src2;
      logic             id_use_src1;
      logic             id_use_src2;
      logic [REG_W-1:0] exe_dest;
      logic             exe_wb_en;
      logic             exe_mem_read;
      logic [REG_W-1:0] mem_dest;
      logic             mem_wb_en;
      logic             exe_branch_tk;
      logic             exe_status_en;
      logic [3:0]       alu_status;
      logic             mem_access;
      logic             mem_ready;
   } ctrl_req_t;
endpackage

// File: rtl/hazard_flush_ctrl_if.sv
// Stage-side request bundle and the flush/freeze/status responses.
interface hazard_flush_ctrl_if import pipe_ctrl_pkg::*; #(parameter int CNT_W = 16);
   ctrl_req_t        req;
   logic             flush;
   logic             freeze_front;
   logic             bubble_id;
   logic             freeze_pipe;
   logic [3:0]       status_q;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_cycles;

   modport master (output req,
                   input  flush, freeze_front, bubble_id, freeze_pipe,
                          status_q, mem_timeout, stall_cycles);
   modport slave  (input  req,
                   output flush, freeze_front, bubble_id, freeze_pipe,
                          status_q, mem_timeout, stall_cycles);
endinterface

// File: rtl/hazard_flush_ctrl_raw_hazard_detect.sv
// Combinational RAW detection between the ID sources and EXE/MEM destinations.
module raw_hazard_detect import pipe_ctrl_pkg::*; #(
   parameter bit FWD_EN = 1'b1
) (
   input  logic [REG_W-1:0] src1,
   input  logic [REG_W-1:0] src2,
   input  logic             use_src1,
   input  logic             use_src2,
   input  logic [REG_W-1:0] exe_dest,
   input  logic             exe_wb_en,
   input  logic             exe_mem_read,
   input  logic [REG_W-1:0] mem_dest,
   input  logic             mem_wb_en,
   output logic             raw
);
   logic exe_hit1, exe_hit2, mem_hit1, mem_hit2, hit1, hit2;

   assign exe_hit1 = exe_wb_en & (src1 == exe_dest);
   assign exe_hit2 = exe_wb_en & (src2 == exe_dest);
   assign mem_hit1 = mem_wb_en & (src1 == mem_dest);
   assign mem_hit2 = mem_wb_en & (src2 == mem_dest);

   // With forwarding only a load in EXE cannot be bypassed in time.
   assign hit1 = FWD_EN ? (exe_mem_read & exe_hit1) : (exe_hit1 | mem_hit1);
   assign hit2 = FWD_EN ? (exe_mem_read & exe_hit2) : (exe_hit2 | mem_hit2);

   assign raw = (use_src1 & hit1) | (use_src2 & hit2);
endmodule

// File: rtl/hazard_flush_ctrl.sv
// Pipeline flush/freeze controller: RAW bubbles, multi-cycle branch flush,
// memory-wait freeze with sticky timeout, NZCV register and stall counter.
module hazard_flush_ctrl import pipe_ctrl_pkg::*; #(
   parameter bit FWD_EN       = 1'b1,
   parameter int FLUSH_CYCLES = 1,
   parameter int MEM_TIMEOUT  = 16,
   parameter int CNT_W        = 16
) (
   input logic               clk,
   input logic               rst,
   hazard_flush_ctrl_if.slave bus
);
   localparam int FL_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
   localparam int WT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

   ctrl_req_t        r;
   state_t           state, state_nx;
   logic [FL_W-1:0]  fl_cnt, fl_cnt_nx;
   logic [WT_W-1:0]  wait_cnt, wait_cnt_nx;
   logic             timeout_set;
   logic             raw, mem_stall;
   logic             flush_c, freeze_c, bubble_c;
   logic [3:0]       status_r;
   logic             timeout_r;
   logic [CNT_W-1:0] stall_r;

   assign r = bus.req;

   raw_hazard_detect #(.FWD_EN(FWD_EN)) u_raw (
      .src1(r.id_src1), .src2(r.id_src2),
      .use_src1(r.id_use_src1), .use_src2(r.id_use_src2),
      .exe_dest(r.exe_dest), .exe_wb_en(r.exe_wb_en), .exe_mem_read(r.exe_mem_read),
      .mem_dest(r.mem_dest), .mem_wb_en(r.mem_wb_en),
      .raw(raw)
   );

   assign mem_stall = r.mem_access & ~r.mem_ready;

   // A taken branch held in EXE during a memory wait flushes once the wait ends.
   assign freeze_c = ~rst & mem_stall;
   assign flush_c  = ~rst & ((~mem_stall & r.exe_branch_tk) | (state == FLUSH));
   assign bubble_c = ~rst & raw & ~flush_c & ~mem_stall;

   assign bus.flush        = flush_c;
   assign bus.freeze_front = bubble_c;
   assign bus.bubble_id    = bubble_c;
   assign bus.freeze_pipe  = freeze_c;
   assign bus.status_q     = status_r;
   assign bus.mem_timeout  = timeout_r;
   assign bus.stall_cycles = stall_r;

   always_comb begin
      state_nx    = state;
      fl_cnt_nx   = fl_cnt;
      wait_cnt_nx = wait_cnt;
      timeout_set = 1'b0;
      case (state)
         RUN: begin
            if (mem_stall) begin
               state_nx    = MEM_WAIT;
               wait_cnt_nx = WT_W'(1);
            end else if (r.exe_branch_tk && FLUSH_CYCLES > 1) begin
               state_nx  = FLUSH;
               fl_cnt_nx = FL_W'(FLUSH_CYCLES - 1);
            end
         end
         FLUSH: begin
            fl_cnt_nx = fl_cnt - FL_W'(1);
            if (fl_cnt == FL_W'(1)) begin
               if (mem_stall) begin
                  state_nx    = MEM_WAIT;
                  wait_cnt_nx = WT_W'(1);
               end else begin
                  state_nx = RUN;
               end
            end
         end
         MEM_WAIT: begin
            if (mem_stall) begin
               if (wait_cnt == WT_W'(MEM_TIMEOUT)) timeout_set = 1'b1;
               if (wait_cnt != '1) wait_cnt_nx = wait_cnt + WT_W'(1);
            end else begin
               state_nx    = RUN;
               wait_cnt_nx = '0;
            end
         end
         default: state_nx = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RUN;
         fl_cnt    <= '0;
         wait_cnt  <= '0;
         status_r  <= '0;
         timeout_r <= 1'b0;
         stall_r   <= '0;
      end else begin
         state     <= state_nx;
         fl_cnt    <= fl_cnt_nx;
         wait_cnt  <= wait_cnt_nx;
         timeout_r <= timeout_r | timeout_set;
         // The EXE instruction survives its own flush, so only a freeze blocks it.
         if (r.exe_status_en && !mem_stall) status_r <= r.alu_status;
         if ((bubble_c || freeze_c) && stall_r != '1) stall_r <= stall_r + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Drives one request stream into a forwarding and a non-forwarding controller
// and compares both against a cycle-level behavioural model.
module tb_hazard_flush_ctrl;
   import pipe_ctrl_pkg::*;

   localparam int FC = 3;
   localparam int MT = 8;
   localparam int CW = 16;

   logic      clk = 1'b0;
   logic      rst = 1'b1;
   ctrl_req_t req = '0;

   int total = 0;
   int bad   = 0;

   // model state: remaining forced-flush cycles, cycles spent waiting (0 = not waiting)
   int       m_flrem  = 0;
   int       m_waited = 0;
   bit       m_tmo    = 1'b0;
   bit [3:0] m_st     = '0;
   int       m_sc[2]  = '{0, 0};

   always #5 clk = ~clk;

   hazard_flush_ctrl_if #(.CNT_W(CW)) if0 ();
   hazard_flush_ctrl_if #(.CNT_W(CW)) if1 ();
   assign if0.req = req;
   assign if1.req = req;

   hazard_flush_ctrl #(.FWD_EN(1'b1), .FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT), .CNT_W(CW))
      dut0 (.clk(clk), .rst(rst), .bus(if0));
   hazard_flush_ctrl #(.FWD_EN(1'b0), .FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT), .CNT_W(CW))
      dut1 (.clk(clk), .rst(rst), .bus(if1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_hit(input int fwd, input logic [3:0] s);
      if (fwd != 0) return req.exe_mem_read && req.exe_wb_en && s == req.exe_dest;
      return (req.exe_wb_en && s == req.exe_dest) || (req.mem_wb_en && s == req.mem_dest);
   endfunction

   function automatic bit m_raw(input int fwd);
      return (req.id_use_src1 && m_hit(fwd, req.id_src1)) ||
             (req.id_use_src2 && m_hit(fwd, req.id_src2));
   endfunction

   task automatic check_dut(input int d, input bit e_fl, input bit e_bub, input bit e_fp,
                            input logic fl, input logic ff, input logic bub, input logic fp,
                            input logic [3:0] st, input logic mt, input logic [CW-1:0] sc);
      string p;
      p = (d == 0) ? "fwd" : "nofwd";
      chk({p, "_flush"}, fl, e_fl);
      chk({p, "_freeze_front"}, ff, e_bub);
      chk({p, "_bubble_id"}, bub, e_bub);
      chk({p, "_freeze_pipe"}, fp, e_fp);
      chk({p, "_status_q"}, st, m_st);
      chk({p, "_mem_timeout"}, mt, m_tmo);
      chk({p, "_stall_cycles"}, sc, m_sc[d]);
   endtask

   // Called just after a falling edge with req already applied.
   task automatic step();
      bit stall, fl;
      bit [1:0] bub;
      #1;
      stall = req.mem_access && !req.mem_ready;
      fl    = (!stall && req.exe_branch_tk) || m_flrem > 0;
      for (int d = 0; d < 2; d++) bub[d] = m_raw(1 - d) && !fl && !stall;
      check_dut(0, fl, bub[0], stall, if0.flush, if0.freeze_front, if0.bubble_id,
                if0.freeze_pipe, if0.status_q, if0.mem_timeout, if0.stall_cycles);
      check_dut(1, fl, bub[1], stall, if1.flush, if1.freeze_front, if1.bubble_id,
                if1.freeze_pipe, if1.status_q, if1.mem_timeout, if1.stall_cycles);
      @(posedge clk);
      if (m_flrem > 0) begin
         m_flrem--;
         if (m_flrem == 0 && stall) m_waited = 1;
      end else if (m_waited > 0) begin
         if (stall) begin
            if (m_waited == MT) m_tmo = 1'b1;
            m_waited++;
         end else begin
            m_waited = 0;
         end
      end else if (stall) begin
         m_waited = 1;
      end else if (req.exe_branch_tk && FC > 1) begin
         m_flrem = FC - 1;
      end
      if (req.exe_status_en && !stall) m_st = req.alu_status;
      for (int d = 0; d < 2; d++)
         if ((bub[d] || stall) && m_sc[d] < 65535) m_sc[d]++;
      @(negedge clk);
   endtask

   // Asserts reset between clock edges with the current inputs still applied.
   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      chk("rst_flush", {if1.flush, if0.flush}, 2'b00);
      chk("rst_freeze_front", {if1.freeze_front, if0.freeze_front}, 2'b00);
      chk("rst_bubble_id", {if1.bubble_id, if0.bubble_id}, 2'b00);
      chk("rst_freeze_pipe", {if1.freeze_pipe, if0.freeze_pipe}, 2'b00);
      chk("rst_status_q", {if1.status_q, if0.status_q}, 8'h00);
      chk("rst_mem_timeout", {if1.mem_timeout, if0.mem_timeout}, 2'b00);
      chk("rst_stall_cycles", {if1.stall_cycles, if0.stall_cycles}, 32'h0);
      m_flrem = 0; m_waited = 0; m_tmo = 1'b0; m_st = '0; m_sc = '{0, 0};
      @(negedge clk);
      req = '0;
      rst = 1'b0;
   endtask

   initial begin
      do_reset();

      // load-use in EXE: both variants bubble, one stall cycle counted
      req.exe_mem_read = 1'b1; req.exe_wb_en = 1'b1; req.exe_dest = 4'd3;
      req.id_src1 = 4'd3; req.id_use_src1 = 1'b1;
      step();
      req = '0;
      chk("t1_stall_cycles", if0.stall_cycles, 1);

      // MEM-stage match only matters without forwarding
      do_reset();
      req.mem_wb_en = 1'b1; req.mem_dest = 4'd7; req.id_src2 = 4'd7; req.id_use_src2 = 1'b1;
      step();
      req.id_use_src2 = 1'b0;
      step();
      chk("t2_nofwd_stalls", if1.stall_cycles, 1);
      chk("t2_fwd_stalls", if0.stall_cycles, 0);

      // taken branch with a pending hazard: three flush cycles, no bubbles
      do_reset();
      req.exe_mem_read = 1'b1; req.exe_wb_en = 1'b1; req.exe_dest = 4'd3;
      req.id_src1 = 4'd3; req.id_use_src1 = 1'b1; req.exe_branch_tk = 1'b1;
      step();
      req.exe_branch_tk = 1'b0;
      repeat (3) step();
      chk("t3_stall_cycles", if0.stall_cycles, 1);

      // flags blocked while frozen, taken on the ready cycle
      do_reset();
      req.mem_access = 1'b1; req.exe_status_en = 1'b1; req.alu_status = 4'b1001;
      repeat (3) step();
      chk("t4_status_frozen", if0.status_q, 4'b0000);
      req.mem_ready = 1'b1;
      step();
      chk("t4_status_updated", if0.status_q, 4'b1001);
      req = '0;
      step();

      // long memory wait sets the sticky timeout
      do_reset();
      req.mem_access = 1'b1;
      repeat (8) step();
      chk("t5_timeout_early", if0.mem_timeout, 1'b0);
      repeat (2) step();
      chk("t5_timeout_set", if0.mem_timeout, 1'b1);
      req.mem_ready = 1'b1;
      step();
      req = '0;
      step();
      chk("t5_timeout_sticky", if0.mem_timeout, 1'b1);
      chk("t5_stall_cycles", if1.stall_cycles, 10);

      // reset inside MEM_WAIT (timeout still set) and inside FLUSH
      req.mem_access = 1'b1;
      repeat (2) step();
      do_reset();
      step();
      req.exe_branch_tk = 1'b1;
      step();
      req.exe_branch_tk = 1'b0;
      do_reset();
      step();

      // randomized traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         req.id_src1       = 4'($urandom_range(0, 3));
         req.id_src2       = 4'($urandom_range(0, 3));
         req.id_use_src1   = 1'($urandom);
         req.id_use_src2   = 1'($urandom);
         req.exe_dest      = 4'($urandom_range(0, 3));
         req.exe_wb_en     = 1'($urandom);
         req.exe_mem_read  = 1'($urandom);
         req.mem_dest      = 4'($urandom_range(0, 3));
         req.mem_wb_en     = 1'($urandom);
         req.exe_branch_tk = ($urandom_range(0, 7) == 0);
         req.exe_status_en = 1'($urandom);
         req.alu_status    = 4'($urandom);
         req.mem_access    = ($urandom_range(0, 2) == 0) || (m_waited > 0 && $urandom_range(0, 3) != 0);
         req.mem_ready     = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 79) == 0) do_reset();
         else step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
